// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state type and width helper for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/mem_arbiter_picker.sv
// mem_arb_picker: combinational requester selection; MEM_ARB_RR_EN picks round-robin from rr_ptr, else lowest index wins
module mem_arb_picker #(
  parameter int N_REQ = 2,
  parameter int GRANT_W = 1
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] rr_ptr,
  output logic               valid,
  output logic [GRANT_W-1:0] grant
);
  assign valid = |req;
`ifdef MEM_ARB_RR_EN
  logic [GRANT_W-1:0] idx;
  // walk downward so the candidate closest to rr_ptr is written last and wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = GRANT_W'((int'(rr_ptr) + k) % N_REQ);
      if (req[idx]) grant = idx;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^rr_ptr;
  always_comb begin
    grant = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[i]) grant = GRANT_W'(i);
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-requester arbiter onto one held-until-resp memory port; MEM_ARB_RR_EN selects round-robin over fixed priority
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_read,
  input  logic [N_REQ-1:0]           req_write,
  input  logic [N_REQ*(DATA_W/8)-1:0] req_byte_enable,
  input  logic [N_REQ*ADDR_W-1:0]    req_address,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  output logic [N_REQ-1:0]           req_resp,
  output logic [DATA_W-1:0]          req_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [DATA_W/8-1:0]        mem_byte_enable,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_resp,
  input  logic [DATA_W-1:0]          mem_rdata
);
  localparam int BE_W = DATA_W / 8;
  localparam int GRANT_W = (N_REQ > 1) ? clog2(N_REQ) : 1;
  arb_state_t state, state_next;
  logic [GRANT_W-1:0] grant, pick, rr_ptr;
  logic pick_valid, op_write;
  mem_arb_picker #(.N_REQ(N_REQ), .GRANT_W(GRANT_W)) u_picker (
    .req(req_read | req_write),
    .rr_ptr(rr_ptr),
    .valid(pick_valid),
    .grant(pick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ARB_IDLE;
    else state <= state_next;
  always_comb
    state_next = (state == ARB_IDLE) ? (pick_valid ? ARB_BUSY : ARB_IDLE)
                                     : (mem_resp ? ARB_IDLE : ARB_BUSY);
  // command is captured only on the IDLE->BUSY edge and frozen until the response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant <= '0;
      rr_ptr <= '0;
      op_write <= 1'b0;
      mem_byte_enable <= '0;
      mem_address <= '0;
      mem_wdata <= '0;
    end else if (state == ARB_IDLE && pick_valid) begin
      grant <= pick;
      rr_ptr <= (pick == GRANT_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
      op_write <= req_write[pick];
      mem_byte_enable <= req_byte_enable[pick*BE_W +: BE_W];
      mem_address <= req_address[pick*ADDR_W +: ADDR_W];
      mem_wdata <= req_wdata[pick*DATA_W +: DATA_W];
    end
  always_comb begin
    mem_read = state == ARB_BUSY && !op_write;
    mem_write = state == ARB_BUSY && op_write;
    req_resp = '0;
    req_resp[grant] = mem_resp && state == ARB_BUSY;
  end
  assign req_rdata = mem_rdata;
`ifndef SYNTHESIS
  for (genvar i = 0; i < N_REQ; i++) begin : g_rw_chk
    always @(posedge clk)
      if (!rst) assert (!(req_read[i] && req_write[i]))
        else $warning("mem_arbiter: port %0d drives read and write together, treated as write", i);
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven vectors plus directed sequences for priority, reset and round-robin
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] rd, wr, resp;
  logic [7:0] be;
  logic [63:0] addr, wd;
  logic mresp, m_read, m_write;
  logic [31:0] mrdata, rdata, m_addr, m_wdata;
  logic [3:0] m_be;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_read(rd), .req_write(wr), .req_byte_enable(be),
    .req_address(addr), .req_wdata(wd), .req_resp(resp), .req_rdata(rdata),
    .mem_read(m_read), .mem_write(m_write), .mem_byte_enable(m_be),
    .mem_address(m_addr), .mem_wdata(m_wdata), .mem_resp(mresp), .mem_rdata(mrdata)
  );
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  typedef struct {
    logic [1:0] rd, wr;
    logic [3:0] be0;
    logic [31:0] a0, a1, wd0;
    logic mr;
    logic [31:0] mrd;
    logic erd, ewr;
    logic [3:0] ebe;
    logic [31:0] eaddr, ewd;
    logic [1:0] eresp;
    logic [31:0] erdata;
  } vec_t;
  vec_t tv[14];
`ifdef MEM_ARB_RR_EN
  logic [2:0] rd3, resp3;
  logic mresp3, m3_read, m3_write;
  logic [31:0] rdata3, m3_addr, m3_wdata;
  logic [3:0] m3_be;
  mem_arbiter #(.N_REQ(3), .ADDR_W(32), .DATA_W(32)) u3 (
    .clk(clk), .rst(rst), .req_read(rd3), .req_write(3'b000), .req_byte_enable(12'hFFF),
    .req_address({32'h1020, 32'h1010, 32'h1000}), .req_wdata(96'h0), .req_resp(resp3),
    .req_rdata(rdata3), .mem_read(m3_read), .mem_write(m3_write), .mem_byte_enable(m3_be),
    .mem_address(m3_addr), .mem_wdata(m3_wdata), .mem_resp(mresp3), .mem_rdata(32'h0)
  );
`endif
  initial begin
    int f, s;
    logic [2:0] drop;
    //          rd     wr     be0   a0        a1      wd0       mr    mrd            erd  ewr  ebe   eaddr     ewd       eresp  erdata
    tv[0]  = '{2'b10, 2'b00, 4'h0, 32'h0,   32'h40, 32'h0,    1'b0, 32'h0,        1'b0,1'b0,4'h0, 32'h0,   32'h0,    2'b00, 32'h0};
    tv[1]  = '{2'b10, 2'b00, 4'h0, 32'h0,   32'h40, 32'h0,    1'b0, 32'h0,        1'b1,1'b0,4'hF, 32'h40,  32'h0,    2'b00, 32'h0};
    tv[2]  = '{2'b10, 2'b00, 4'h0, 32'h0,   32'h40, 32'h0,    1'b0, 32'h0,        1'b1,1'b0,4'hF, 32'h40,  32'h0,    2'b00, 32'h0};
    tv[3]  = '{2'b10, 2'b00, 4'h0, 32'h0,   32'h40, 32'h0,    1'b1, 32'hDEADBEEF, 1'b1,1'b0,4'hF, 32'h40,  32'h0,    2'b10, 32'hDEADBEEF};
    tv[4]  = '{2'b00, 2'b00, 4'h0, 32'h0,   32'h0,  32'h0,    1'b0, 32'h0,        1'b0,1'b0,4'hF, 32'h40,  32'h0,    2'b00, 32'h0};
    tv[5]  = '{2'b00, 2'b00, 4'h0, 32'h0,   32'h0,  32'h0,    1'b1, 32'h55,       1'b0,1'b0,4'hF, 32'h40,  32'h0,    2'b00, 32'h55};
    tv[6]  = '{2'b00, 2'b01, 4'h3, 32'h200, 32'h0,  32'h1234, 1'b0, 32'h0,        1'b0,1'b0,4'hF, 32'h40,  32'h0,    2'b00, 32'h0};
    tv[7]  = '{2'b00, 2'b01, 4'h3, 32'h300, 32'h0,  32'hFFFF, 1'b0, 32'h0,        1'b0,1'b1,4'h3, 32'h200, 32'h1234, 2'b00, 32'h0};
    tv[8]  = '{2'b00, 2'b01, 4'h3, 32'h300, 32'h0,  32'hFFFF, 1'b1, 32'h0,        1'b0,1'b1,4'h3, 32'h200, 32'h1234, 2'b01, 32'h0};
    tv[9]  = '{2'b00, 2'b00, 4'h0, 32'h0,   32'h0,  32'h0,    1'b0, 32'h0,        1'b0,1'b0,4'h3, 32'h200, 32'h1234, 2'b00, 32'h0};
    tv[10] = '{2'b01, 2'b01, 4'hC, 32'h400, 32'h0,  32'hAAAA, 1'b0, 32'h0,        1'b0,1'b0,4'h3, 32'h200, 32'h1234, 2'b00, 32'h0};
    tv[11] = '{2'b01, 2'b01, 4'hC, 32'h400, 32'h0,  32'hAAAA, 1'b0, 32'h0,        1'b0,1'b1,4'hC, 32'h400, 32'hAAAA, 2'b00, 32'h0};
    tv[12] = '{2'b01, 2'b01, 4'hC, 32'h400, 32'h0,  32'hAAAA, 1'b1, 32'h77,       1'b0,1'b1,4'hC, 32'h400, 32'hAAAA, 2'b01, 32'h77};
    tv[13] = '{2'b00, 2'b00, 4'h0, 32'h0,   32'h0,  32'h0,    1'b0, 32'h0,        1'b0,1'b0,4'hC, 32'h400, 32'hAAAA, 2'b00, 32'h0};
    rd = '0; wr = '0; be = '0; addr = '0; wd = '0; mresp = 1'b0; mrdata = '0;
`ifdef MEM_ARB_RR_EN
    rd3 = '0; mresp3 = 1'b0;
`endif
    @(negedge clk);
    chk("reset_state", {m_read, m_write, m_be, m_addr, m_wdata, resp}, '0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      rd = tv[i].rd; wr = tv[i].wr; be = {4'hF, tv[i].be0};
      addr = {tv[i].a1, tv[i].a0}; wd = {32'h0, tv[i].wd0};
      mresp = tv[i].mr; mrdata = tv[i].mrd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {m_read, m_write, m_be, m_addr, m_wdata, resp, rdata},
          {tv[i].erd, tv[i].ewr, tv[i].ebe, tv[i].eaddr, tv[i].ewd, tv[i].eresp, tv[i].erdata});
      @(posedge clk); #1;
    end
`ifdef MEM_ARB_RR_EN
    f = 1; s = 0;
`else
    f = 0; s = 1;
`endif
    rd = 2'b11; wr = '0; addr = {32'h20, 32'h10}; mresp = 1'b0;
    @(posedge clk); #1 mresp = 1'b1;
    @(negedge clk);
    chk("simul_first", {m_read, m_addr, resp}, {1'b1, 32'h10 * (f + 1), 2'(1 << f)});
    @(posedge clk); #1 rd[f] = 1'b0; mresp = 1'b0;
    @(negedge clk);
    chk("simul_gap_idle", {m_read, resp}, '0);
    @(posedge clk); #1 mresp = 1'b1;
    @(negedge clk);
    chk("simul_second", {m_read, m_addr, resp}, {1'b1, 32'h10 * (s + 1), 2'(1 << s)});
    @(posedge clk); #1 rd = '0; mresp = 1'b0;
    rd = 2'b01; addr = {32'h0, 32'h100};
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_busy", {m_read, m_addr}, {1'b1, 32'h100});
    #2 rst = 1'b1; mresp = 1'b1;
    #1 chk("rst_async_drop", {m_read, m_write, m_addr, resp}, '0);
    @(posedge clk); #1 rst = 1'b0; rd = '0;
    @(negedge clk);
    chk("rst_resp_ignored", {m_read, m_write, resp}, '0);
    @(posedge clk); #1 mresp = 1'b0;
`ifdef MEM_ARB_RR_EN
    drop = '0;
    for (int j = 0; j < 30; j++) begin
      rd3 = 3'b111 & ~drop;
      @(posedge clk); #1 mresp3 = 1'b1;
      @(negedge clk);
      chk($sformatf("rr_txn%0d", j), {m3_read, m3_addr, resp3},
          {1'b1, 32'h1000 + 32'h10 * (j % 3), 3'(1 << (j % 3))});
      @(posedge clk); #1 mresp3 = 1'b0; drop = 3'(1 << (j % 3));
    end
    rd3 = '0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
